ild_spike_set_reset_driver: RTL and testbench

- Drives the SET/RST inputs of the LSO ILD estimator neuron (hold-and-fire latch, output HOLD_PULSE).
- Takes left-ear and right-ear spike streams and integrates their difference in a leaky, saturating signed accumulator.
- When left dominance crosses a threshold it emits a SET pulse. When right dominance crosses it, it emits a RST pulse.
- Each pulse is followed by a refractory window.

---
 rtl/ild_spike_set_reset_driver.sv | 161 ++++++++++++++++
 tb/tb_ild_spike_set_reset_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ild_spike_set_reset_driver.sv
// SET/RST pulse driver for the LSO ILD hold-and-fire neuron: integrates the
// left/right spike difference in a leaky saturating accumulator and fires pulses.
module ild_spike_set_reset_driver #(
  parameter int unsigned ACC_WIDTH    = 8,
  parameter int unsigned THRESHOLD    = 16,
  parameter int unsigned LEAK_PERIOD  = 1000,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned REFRACTORY   = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SPIKE_LEFT,
  input  logic                        SPIKE_RIGHT,
  output logic                        SET_OUT,
  output logic                        RST_OUT,
  output logic                        BUSY,
  output logic signed [ACC_WIDTH-1:0] ACC_OUT
);

  localparam int unsigned SW   = ACC_WIDTH + 2;
  localparam int unsigned LW   = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int unsigned CMAX = (PULSE_CYCLES > REFRACTORY) ? PULSE_CYCLES : REFRACTORY;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int          MAXV = (2 ** (ACC_WIDTH - 1)) - 1;
  localparam int          THR  = int'(THRESHOLD);

  localparam logic signed [SW-1:0] ACC_MAX    = SW'(MAXV);
  localparam logic signed [SW-1:0] ACC_MIN    = SW'(-MAXV);
  localparam logic signed [SW-1:0] THR_POS    = SW'(THR);
  localparam logic signed [SW-1:0] THR_NEG    = SW'(-THR);
  localparam logic [LW-1:0]        LK_LAST    = LW'(LEAK_PERIOD - 1);
  localparam logic [CW-1:0]        PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]        REFR_LAST  = CW'((REFRACTORY > 0) ? REFRACTORY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    FIRE_SET,
    FIRE_RST,
    REFRACT
  } state_t;

  logic [1:0]                 rst_sync_q;
  logic                       rst_n_int;
  state_t                     state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LW-1:0]              lk_q, lk_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       set_q, set_d;
  logic                       rstp_q, rstp_d;

  logic                       lk_wrap;
  logic signed [SW-1:0]       delta_s, leak_s, sum_s, acc_next;

  // Assertion propagates asynchronously; release reaches the core two edges later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= IDLE;
      acc_q   <= '0;
      lk_q    <= '0;
      cnt_q   <= '0;
      set_q   <= 1'b0;
      rstp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lk_q    <= lk_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      rstp_q  <= rstp_d;
    end
  end

  // Candidate accumulator value for an IDLE cycle: spike delta plus leak, clamped symmetric.
  always_comb begin
    lk_wrap = (lk_q == LK_LAST);
    lk_d    = lk_wrap ? '0 : lk_q + LW'(1);

    delta_s = '0;
    if (SPIKE_LEFT && !SPIKE_RIGHT)      delta_s = SW'(1);
    else if (!SPIKE_LEFT && SPIKE_RIGHT) delta_s = '1;

    leak_s = '0;
    if (lk_wrap && (acc_q != '0)) begin
      if (acc_q[ACC_WIDTH-1]) leak_s = SW'(1);
      else                    leak_s = '1;
    end

    sum_s = SW'(acc_q) + delta_s + leak_s;

    if (sum_s > ACC_MAX)      acc_next = ACC_MAX;
    else if (sum_s < ACC_MIN) acc_next = ACC_MIN;
    else                      acc_next = sum_s;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    rstp_d  = rstp_q;

    unique case (state_q)
      IDLE: begin
        acc_d = $signed(acc_next[ACC_WIDTH-1:0]);
        if (acc_next >= THR_POS) begin
          state_d = FIRE_SET;
          acc_d   = '0;
          set_d   = 1'b1;
          cnt_d   = PULSE_LAST;
        end else if (acc_next <= THR_NEG) begin
          state_d = FIRE_RST;
          acc_d   = '0;
          rstp_d  = 1'b1;
          cnt_d   = PULSE_LAST;
        end
      end

      FIRE_SET, FIRE_RST: begin
        acc_d = '0;
        if (cnt_q == '0) begin
          set_d  = 1'b0;
          rstp_d = 1'b0;
          if (REFRACTORY == 0) begin
            state_d = IDLE;
          end else begin
            state_d = REFRACT;
            cnt_d   = REFR_LAST;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      REFRACT: begin
        acc_d = '0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        set_d   = 1'b0;
        rstp_d  = 1'b0;
      end
    endcase
  end

  assign SET_OUT = set_q;
  assign RST_OUT = rstp_q;
  assign BUSY    = (state_q != IDLE);
  assign ACC_OUT = acc_q;

endmodule

// File: tb/tb_ild_spike_set_reset_driver.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations tagged
// with a target cycle; a negedge monitor pops and compares them.
module tb_ild_spike_set_reset_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       l1 = 1'b0, r1 = 1'b0, l2 = 1'b0, r2 = 1'b0;
  logic       set1, rst1, busy1, set2, rst2, busy2;
  logic signed [5:0] acc1, acc2;

  always #5 CLK = ~CLK;

  ild_spike_set_reset_driver #(
    .ACC_WIDTH(6), .THRESHOLD(4), .LEAK_PERIOD(8), .PULSE_CYCLES(3), .REFRACTORY(5)
  ) u_dut (
    .CLK(CLK), .RST(RST), .SPIKE_LEFT(l1), .SPIKE_RIGHT(r1),
    .SET_OUT(set1), .RST_OUT(rst1), .BUSY(busy1), .ACC_OUT(acc1)
  );

  // Same timing, threshold at the largest positive code.
  ild_spike_set_reset_driver #(
    .ACC_WIDTH(6), .THRESHOLD(31), .LEAK_PERIOD(8), .PULSE_CYCLES(3), .REFRACTORY(5)
  ) u_dut_sat (
    .CLK(CLK), .RST(RST), .SPIKE_LEFT(l2), .SPIKE_RIGHT(r2),
    .SET_OUT(set2), .RST_OUT(rst2), .BUSY(busy2), .ACC_OUT(acc2)
  );

  typedef struct {
    int    cyc;
    int    dut;
    bit    s;
    bit    r;
    bit    b;
    int    a;
    string nm;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    j = 0;
  int    total = 0;
  int    bad = 0;

  int sat_tbl [34] = '{1, 2, 3, 4, 5, 6, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15,
                       16, 17, 18, 19, 20, 20, 21, 22, 23, 24, 25, 26, 27, 27,
                       28, 29, 30};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input int dut, input bit s, input bit r, input bit b,
                      input int a, input string nm, input bit now);
    exp_t e;
    e.cyc = now ? cyc : cyc + 1;
    e.dut = dut; e.s = s; e.r = r; e.b = b; e.a = a; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic exp1(input bit s, input bit r, input bit b, input int a, input string nm);
    push(1, s, r, b, a, nm, 1'b0);
  endtask

  task automatic exp2(input bit s, input bit r, input bit b, input int a, input string nm);
    push(2, s, r, b, a, nm, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
    j++;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    l1 = 1'b0; r1 = 1'b0; l2 = 1'b0; r2 = 1'b0;
    push(1, 0, 0, 0, 0, "rst_async", 1'b1);
    push(2, 0, 0, 0, 0, "rst_async", 1'b1);
    repeat (3) begin
      exp1(0, 0, 0, 0, "rst_hold");
      exp2(0, 0, 0, 0, "rst_hold");
      tick();
    end
    RST = 1'b1;
    repeat (2) begin
      exp1(0, 0, 0, 0, "rst_sync");
      exp2(0, 0, 0, 0, "rst_sync");
      tick();
    end
    j = 0;
  endtask

  initial begin : monitor
    exp_t e;
    bit   gs, gr, gb;
    int   ga;
    forever begin
      @(negedge CLK);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.dut == 1) begin
          gs = set1; gr = rst1; gb = busy1; ga = int'(acc1);
        end else begin
          gs = set2; gr = rst2; gb = busy2; ga = int'(acc2);
        end
        total++;
        if (gs !== e.s || gr !== e.r || gb !== e.b || ga != e.a) begin
          bad++;
          $display("FAIL %s dut%0d cyc=%0d: got set=%0b rst=%0b busy=%0b acc=%0d, want set=%0b rst=%0b busy=%0b acc=%0d",
                   e.nm, e.dut, cyc, gs, gr, gb, ga, e.s, e.r, e.b, e.a);
        end
      end
    end
  end

  initial begin : stimulus
    #1;
    do_reset();

    // Quiet run, then align so the next spike lands right after a leak wrap (j=56).
    for (int n = 1; n <= 56; n++) begin
      exp1(0, 0, 0, 0, "idle_quiet");
      tick();
    end

    // Four left spikes j=57..60: 1,2,3 then fire.
    for (int i = 0; i < 4; i++) begin
      l1 = 1'b1;
      exp1(i == 3, 0, i == 3, (i == 3) ? 0 : i + 1, "left_ramp");
      tick();
    end
    l1 = 1'b0;
    for (int n = 61; n <= 68; n++) begin
      exp1(n <= 62, 0, n <= 67, 0, "set_pulse_refract");
      tick();
    end

    // Right spikes from the first IDLE cycle (j=69); leak offsets the spike at j=72.
    begin
      int rexp [4] = '{-1, -2, -3, -3};
      for (int i = 0; i < 4; i++) begin
        r1 = 1'b1;
        exp1(0, 0, 0, rexp[i], "right_ramp");
        tick();
      end
    end
    r1 = 1'b1;
    exp1(0, 1, 1, 0, "right_fire");
    tick();

    // Spikes during BUSY (j=74..80) are discarded.
    for (int n = 74; n <= 81; n++) begin
      l1 = (n <= 77 || n == 78 || n == 80);
      r1 = (n == 78 || n == 79);
      if (n == 81) begin l1 = 1'b0; r1 = 1'b0; end
      exp1(0, n <= 75, n <= 80, 0, "busy_discard");
      tick();
    end
    l1 = 1'b0; r1 = 1'b0;

    // Three left spikes then leak decay at j=88, 96, 104.
    for (int n = 82; n <= 84; n++) begin
      l1 = 1'b1;
      exp1(0, 0, 0, n - 81, "leak_ramp");
      tick();
    end
    l1 = 1'b0;
    for (int n = 85; n <= 108; n++) begin
      exp1(0, 0, 0, (n < 88) ? 3 : (n < 96) ? 2 : (n < 104) ? 1 : 0, "leak_decay");
      tick();
    end

    // Build to 3, then both spikes together: only leak moves acc.
    for (int n = 109; n <= 111; n++) begin
      l1 = 1'b1;
      exp1(0, 0, 0, n - 108, "both_pre");
      tick();
    end
    for (int n = 112; n <= 121; n++) begin
      l1 = 1'b1; r1 = 1'b1;
      exp1(0, 0, 0, (n < 120) ? 2 : 1, "both_cancel");
      tick();
    end
    l1 = 1'b0; r1 = 1'b0;

    // 40 left spikes into the threshold-31 instance: climbs to 31, fires once.
    for (int n = 122; n <= 161; n++) begin
      l2 = 1'b1;
      exp1(0, 0, 0, (n < 128) ? 1 : 0, "dut1_quiet_leak");
      exp2(n >= 156 && n <= 158, 0, n >= 156, (n < 156) ? sat_tbl[n - 122] : 0, "sat_ramp");
      tick();
    end
    l2 = 1'b0;
    for (int n = 162; n <= 165; n++) begin
      exp1(0, 0, 0, 0, "dut1_idle");
      exp2(0, 0, n <= 163, 0, "sat_refract");
      tick();
    end

    // Fire again (leak at j=168), then reset during the second SET cycle.
    begin
      int fexp [5] = '{1, 2, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
        l1 = 1'b1;
        exp1(i == 4, 0, i == 4, fexp[i], "refire");
        tick();
      end
    end
    l1 = 1'b0;
    tick();
    do_reset();

    // Normal behaviour after release.
    for (int i = 0; i < 4; i++) begin
      l1 = 1'b1;
      exp1(i == 3, 0, i == 3, (i == 3) ? 0 : i + 1, "post_rst_ramp");
      tick();
    end
    l1 = 1'b0;
    for (int n = 5; n <= 14; n++) begin
      exp1(n <= 6, 0, n <= 11, 0, "post_rst_pulse");
      tick();
    end

    @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
